dmem_ctrl: RTL and testbench

- Parametrised, clocked successor to the testbench data memory.
- Word-array RAM behind a valid/ready request/response handshake, with configurable access latency, byte/half/word sizes, sign/zero extension and misalignment detection.
- Sits between the core's load/store unit and backing storage in the testbench. Lets the LSU be exercised under wait states.

---
 rtl/dmem_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
`timescale 1ns/1ps
// dmem_ctrl: word-array data memory behind a valid/ready request/response handshake,
// with configurable access latency, byte/half/word sizes and sign/zero extension.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses respond with an
// error and suppress stores. Without it, misaligned offsets are force-aligned.
module dmem_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CntW    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned CntInit = (LATENCY >= 2) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Latched request fields
  logic [AW+1:0]   addr_q;
  logic            write_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [31:0]     wdata_q;

  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  // Zero at power-up; reset leaves contents alone
  logic [31:0]     mem_q [DEPTH] = '{default: '0};

  // Request as seen at the RESP-entry edge (live inputs when LATENCY == 1)
  logic [AW+1:0]   cur_addr;
  logic            cur_write;
  logic [1:0]      cur_size;
  logic            cur_uns;
  logic [31:0]     cur_wdata;

  logic            accept;
  logic            enter_resp;
  logic [AW-1:0]   idx;
  logic [1:0]      off;
  logic            err;
  logic [3:0]      be;
  logic [31:0]     wlanes;
  logic [31:0]     rd_word;
  logic [31:0]     shifted;
  logic [31:0]     ld_data;
  logic [31:0]     wr_word;
  logic            mem_we;

  logic            unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign accept     = req_valid & req_ready;
  assign enter_resp = (state_d == StResp) && (state_q != StResp);

  // State register and latency counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = StResp;
          end else begin
            state_d = StBusy;
            cnt_d   = CntW'(CntInit);
          end
        end
      end
      StBusy: begin
        if (cnt_q == '0) state_d = StResp;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle:  req_ready  = 1'b1;
      StResp:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

  // Capture request fields on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= req_addr[AW+1:0];
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
    end
  end

  // Select live or latched request fields
  always_comb begin
    if (state_q == StIdle) begin
      cur_addr  = req_addr[AW+1:0];
      cur_write = req_write;
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_wdata = req_wdata;
    end else begin
      cur_addr  = addr_q;
      cur_write = write_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_wdata = wdata_q;
    end
  end

  // Decode address, lanes, load extraction and store merge
  always_comb begin
    idx = cur_addr[AW+1:2];
    off = cur_addr[1:0];
    err = (cur_size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((cur_size == 2'd1 && off[0]) || (cur_size == 2'd2 && off != 2'b00)) err = 1'b1;
`else
    if (cur_size == 2'd1)      off[0] = 1'b0;
    else if (cur_size == 2'd2) off    = 2'b00;
`endif
    case (cur_size)
      2'd0: begin
        be     = 4'b0001 << off;
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'd1: begin
        be     = 4'b0011 << off;
        wlanes = {2{cur_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wlanes = cur_wdata;
      end
    endcase

    rd_word = mem_q[idx];
    shifted = rd_word >> {off, 3'b000};
    case (cur_size)
      2'd0:    ld_data = {{24{~cur_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = {{16{~cur_uns & shifted[15]}}, shifted[15:0]};
      default: ld_data = rd_word;
    endcase

    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : rd_word[8*i +: 8];
    end

    resp_err_d  = err;
    resp_data_d = (err || cur_write) ? 32'd0 : ld_data;
    // A clock edge while rst is high must not commit a store
    mem_we      = enter_resp & cur_write & ~err & ~rst;
  end

  // Response registers, loaded on the edge that enters RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else if (enter_resp) begin
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Store commit
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
`timescale 1ns/1ps
// Bench for dmem_ctrl: one instance with LATENCY 4 and one with LATENCY 1. A byte-array
// memory model predicts each response into a per-instance queue; a negedge monitor
// compares whatever the DUTs present against the queue heads.
module tb_dmem_ctrl;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NB    = DEPTH * 4;
  localparam int unsigned LAT0  = 4;
  localparam int unsigned LAT1  = 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic [31:0] req_addr     [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_data    [2];
  logic        resp_err     [2];

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic        seen [2];
  logic [7:0]  mdl [2][NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_write(req_write[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_err(resp_err[0])
  );

  dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_write(req_write[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_err(resp_err[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // Reference: byte-addressed memory, wrap modulo NB, offset rules from the size.
  function automatic void model(int k, logic [31:0] addr, logic wr, logic [1:0] size,
                                logic uns, logic [31:0] wdata, logic commit,
                                output logic [31:0] d, output logic er);
    int unsigned base, off, nb;
    logic [31:0] v;
    base = ((addr % NB) / 4) * 4;
    off  = addr % 4;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er   = (size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (!er && (off % nb) != 0) er = 1'b1;
`else
    off = off - (off % nb);
`endif
    d = 32'd0;
    if (er) return;
    if (wr) begin
      if (commit) for (int b = 0; b < int'(nb); b++) mdl[k][base + off + b] = wdata[8*b +: 8];
    end else begin
      v = 32'd0;
      for (int b = 0; b < int'(nb); b++) v = v | (32'(mdl[k][base + off + b]) << (8 * b));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      d = v;
    end
  endfunction

  function automatic void push_exp(int k, exp_t e);
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  // Monitor: compare each presented response against the queue head
  always @(negedge clk) begin
    exp_t e;
    int   sz;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        seen[k] = 1'b0;
      end else if (resp_valid[k]) begin
        sz = (k == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
          chk($sformatf("resp_without_request%0d", k), 32'(sz), 32'd1);
        end else begin
          if (k == 0) e = exp_q0[0];
          else        e = exp_q1[0];
          chk($sformatf("resp_data%0d", k), resp_data[k], e.data);
          chk($sformatf("resp_err%0d", k), {31'd0, resp_err[k]}, {31'd0, e.err});
          if (!seen[k]) begin
            chk($sformatf("latency%0d", k), cyc - e.acc + 1, (k == 0) ? 32'(LAT0) : 32'(LAT1));
            seen[k] = 1'b1;
          end
          if (resp_ready[k]) begin
            if (k == 0) void'(exp_q0.pop_front());
            else        void'(exp_q1.pop_front());
            seen[k] = 1'b0;
          end
        end
      end
    end
  end

  // abort: 0 = normal, 1 = reset while BUSY, 2 = reset while RESP
  task automatic issue(int k, logic [31:0] addr, logic wr, logic [1:0] size, logic uns,
                       logic [31:0] wdata, int stall, int abort);
    exp_t        e;
    int          n;
    logic [31:0] d;
    logic        er;
    @(posedge clk); #1;
    req_addr[k]     = addr;
    req_write[k]    = wr;
    req_size[k]     = size;
    req_unsigned[k] = uns;
    req_wdata[k]    = wdata;
    req_valid[k]    = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", {31'd0, n < 50}, 32'd1);
    @(posedge clk); #1;
    e.acc = cyc;
    // Scramble inputs so only latched fields can produce the response
    req_valid[k]    = 1'b0;
    req_addr[k]     = $urandom;
    req_wdata[k]    = $urandom;
    req_size[k]     = 2'($urandom);
    req_write[k]    = 1'($urandom);
    req_unsigned[k] = 1'($urandom);
    model(k, addr, wr, size, uns, wdata, (abort != 1), d, er);
    e.data = d;
    e.err  = er;
    if (abort == 1) begin
      @(posedge clk); #1;
      chk("busy_req_ready", {31'd0, req_ready[k]}, 32'd0);
      rst = 1'b1; #1;
      chk("rst_busy_resp_valid", {31'd0, resp_valid[k]}, 32'd0);
      chk("rst_busy_req_ready", {31'd0, req_ready[k]}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    push_exp(k, e);
    n = 0;
    while (!resp_valid[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_timeout", {31'd0, n < 50}, 32'd1);
    if (abort == 2) begin
      rst = 1'b1; #1;
      chk("rst_resp_resp_valid", {31'd0, resp_valid[k]}, 32'd0);
      chk("rst_resp_req_ready", {31'd0, req_ready[k]}, 32'd1);
      if (k == 0) exp_q0.delete();
      else        exp_q1.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    // Competing request while the response is held must be ignored
    req_valid[k] = 1'b1;
    repeat (stall) begin
      chk("no_accept_in_resp", {31'd0, req_ready[k]}, 32'd0);
      @(posedge clk); #1;
    end
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    req_valid[k]  = 1'b0;
    chk("idle_after_resp", {30'd0, resp_valid[k], req_ready[k]}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; req_write[k] = 1'b0; req_size[k] = 2'd0;
      req_unsigned[k] = 1'b0; req_wdata[k] = '0; resp_ready[k] = 1'b0; seen[k] = 1'b0;
      for (int b = 0; b < int'(NB); b++) mdl[k][b] = 8'h00;
    end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("reset_req_ready", {31'd0, req_ready[k]}, 32'd1);
      chk("reset_resp_valid", {31'd0, resp_valid[k]}, 32'd0);
      chk("reset_resp_data", resp_data[k], 32'd0);
      chk("reset_resp_err", {31'd0, resp_err[k]}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // LATENCY 1 directed
    issue(1, 32'h10,  1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0);
    issue(1, 32'h10,  1'b0, 2'd2, 1'b0, 32'h0, 1, 0);
    issue(1, 32'h31,  1'b1, 2'd0, 1'b0, 32'h80, 0, 0);
    issue(1, 32'h31,  1'b0, 2'd0, 1'b0, 32'h0, 0, 0);
    issue(1, 32'h31,  1'b0, 2'd0, 1'b1, 32'h0, 0, 0);
    issue(1, 32'h30,  1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(1, 32'h40,  1'b1, 2'd2, 1'b0, 32'h11223344, 0, 0);
    issue(1, 32'h42,  1'b1, 2'd1, 1'b0, 32'hA5C3, 0, 0);
    issue(1, 32'h40,  1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(1, 32'h400, 1'b1, 2'd2, 1'b0, 32'h55, 0, 0);
    issue(1, 32'h0,   1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(1, 32'h8,   1'b1, 2'd3, 1'b0, 32'hFFFF, 0, 0);
    issue(1, 32'h8,   1'b0, 2'd3, 1'b0, 32'h0, 0, 0);
    issue(1, 32'h41,  1'b1, 2'd2, 1'b0, 32'hCAFEF00D, 0, 0);
    issue(1, 32'h40,  1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(1, 32'h42,  1'b0, 2'd1, 1'b0, 32'h0, 0, 2);
    issue(1, 32'h42,  1'b0, 2'd1, 1'b1, 32'h0, 0, 0);

    // LATENCY 4 directed
    issue(0, 32'h20, 1'b1, 2'd2, 1'b0, 32'h13579BDF, 0, 0);
    issue(0, 32'h20, 1'b0, 2'd2, 1'b0, 32'h0, 3, 0);
    issue(0, 32'h50, 1'b1, 2'd2, 1'b0, 32'h12345678, 0, 1);
    issue(0, 32'h50, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(0, 32'h54, 1'b1, 2'd2, 1'b0, 32'h9ABCDEF0, 1, 2);
    issue(0, 32'h54, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0);
    issue(0, 32'h40, 1'b1, 2'd2, 1'b0, 32'h01020304, 0, 0);
    issue(0, 32'h43, 1'b1, 2'd1, 1'b0, 32'hBEEF, 0, 0);
    issue(0, 32'h40, 1'b0, 2'd2, 1'b0, 32'h0, 0, 0);

    // Random traffic on both instances
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 150; i++) begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          r;
        int          ab;
        a = $urandom_range(0, 63);
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
        r  = $urandom_range(0, 7);
        sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
        r  = $urandom_range(0, 19);
        ab = (r == 0 && k == 0) ? 1 : (r == 1) ? 2 : 0;
        issue(k, a, 1'($urandom), sz, 1'($urandom), $urandom, $urandom_range(0, 2), ab);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
    chk("queue1_drained", 32'(exp_q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
